imm_ext_pipe: RTL

//  Pipelined, XLEN-parametrised immediate generator for the datapath. Takes a full 32-bit

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_ext_core.sv | 82 ++++++++
 rtl/imm_ext_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate-generation pipeline.
//   - IMM_I .. IMM_Z : encodings of the 3-bit immediate-format select
//   - occ_state_e    : occupancy of the two-entry skid buffer in imm_ext_pipe
// No ports; imported by imm_ext_core, imm_ext_pipe and the testbench.
// ---------------------------------------------------------------------------
package imm_pkg;

    // Immediate format selects as decoded from the instruction
    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_B  = 3'b010;
    localparam logic [2:0] IMM_U  = 3'b011;
    localparam logic [2:0] IMM_J  = 3'b100;
    localparam logic [2:0] IMM_SH = 3'b101;
    localparam logic [2:0] IMM_Z  = 3'b110;

    // How many valid entries the skid buffer currently holds
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage : imm_pkg

// File: rtl/imm_ext_core.sv
// ---------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender. Slices the immediate field out of
// a 32-bit instruction according to the format select and extends it to XLEN.
//
// Parameters
//   XLEN       output width, 32 or 64
// Ports
//   inst_i     in   32    full instruction word
//   imm_src_i  in   3     format select (IMM_I .. IMM_Z from imm_pkg)
//   imm_o      out  XLEN  extended immediate (0 for unsupported formats)
//   err_o      out  1     format select is not supported
//
// Configuration macro: IMM_ZICSR_EN
//   defined   -> IMM_Z returns the zero-extended CSR uimm inst[19:15]
//   undefined -> IMM_Z is treated as unsupported
// ---------------------------------------------------------------------------
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);

    logic [31:0] raw32;
    logic [5:0]  zext;
    logic        isSigned;
    logic        signBit;
    logic        unusedOpcode;

    // The opcode bits never contribute to any immediate
    assign unusedOpcode = ^inst_i[6:0];
    assign signBit      = inst_i[31];

    // Each signed format is first assembled as a fully sign-extended 32-bit
    // value, then widened to XLEN in one place at the end; this keeps the
    // XLEN=32 build free of zero-width replications. Shift amounts and the
    // CSR uimm are unsigned and take the zero-extension path instead.
    always_comb begin
        raw32    = '0;
        zext     = '0;
        isSigned = 1'b1;
        err_o    = 1'b0;
        case (imm_src_i)
            IMM_I:  raw32 = {{20{signBit}}, inst_i[31:20]};
            IMM_S:  raw32 = {{20{signBit}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:  raw32 = {{19{signBit}}, signBit, inst_i[7], inst_i[30:25],
                             inst_i[11:8], 1'b0};
            IMM_U:  raw32 = {inst_i[31:12], 12'b0};
            IMM_J:  raw32 = {{11{signBit}}, signBit, inst_i[19:12], inst_i[20],
                             inst_i[30:21], 1'b0};
            IMM_SH: begin
                isSigned = 1'b0;
                if (XLEN == 64) begin
                    zext = inst_i[25:20];
                end else begin
                    zext = {1'b0, inst_i[24:20]};
                end
            end
`ifdef IMM_ZICSR_EN
            IMM_Z:  begin
                isSigned = 1'b0;
                zext     = {1'b0, inst_i[19:15]};
            end
`endif
            default: begin
                isSigned = 1'b0;
                err_o    = 1'b1;
            end
        endcase
        if (isSigned) begin
            imm_o = XLEN'($signed(raw32));
        end else begin
            imm_o = XLEN'(zext);
        end
    end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// ---------------------------------------------------------------------------
// imm_ext_pipe
// Pipelined immediate generator behind a valid/ready stream. The immediate is
// extended combinationally on the input side and captured into a two-entry
// skid buffer, so in_ready depends only on registered occupancy and never on
// out_ready.
//
// Parameters
//   XLEN       output width, 32 or 64
//   TAG_W      width of the opaque tag carried with each immediate
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous discard of all buffered entries
//   in_valid   in   1      inst/imm_src/in_tag are valid
//   in_ready   out  1      an entry can be accepted this cycle
//   inst       in   32     full instruction word
//   imm_src    in   3      immediate format select
//   in_tag     in   TAG_W  tag travelling with the entry
//   out_valid  out  1      imm/out_tag/imm_err are valid
//   out_ready  in   1      consumer accepts the head entry this cycle
//   imm        out  XLEN   extended immediate of the head entry
//   out_tag    out  TAG_W  tag of the head entry
//   imm_err    out  1      head entry used an unsupported format
//
// Configuration macro: IMM_ZICSR_EN (enables the CSR uimm format in
// imm_ext_core).
// ---------------------------------------------------------------------------
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    occ_state_e       state_q, state_d;

    logic [XLEN-1:0]  headImm_q, headImm_d;
    logic [TAG_W-1:0] headTag_q, headTag_d;
    logic             headErr_q, headErr_d;
    logic [XLEN-1:0]  tailImm_q, tailImm_d;
    logic [TAG_W-1:0] tailTag_q, tailTag_d;
    logic             tailErr_q, tailErr_d;

    logic [XLEN-1:0]  extImm;
    logic             extErr;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .XLEN (XLEN)
    ) u_core (
        .inst_i    (inst),
        .imm_src_i (imm_src),
        .imm_o     (extImm),
        .err_o     (extErr)
    );

    // Both handshake flags come straight from the registered state, which is
    // what removes any combinational path from out_ready to in_ready.
    assign in_ready  = (state_q != OCC_TWO);
    assign out_valid = (state_q != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign imm     = headImm_q;
    assign out_tag = headTag_q;
    assign imm_err = headErr_q;

    // Occupancy and entry-slot next-state logic. The head slot always feeds
    // the outputs; the tail slot is only written when the buffer goes from
    // one to two entries, and is promoted to head when that head drains.
    // Flush takes priority over everything and leaves the slots untouched,
    // since only the occupancy state decides what is visible.
    always_comb begin
        state_d   = state_q;
        headImm_d = headImm_q;
        headTag_d = headTag_q;
        headErr_d = headErr_q;
        tailImm_d = tailImm_q;
        tailTag_d = tailTag_q;
        tailErr_d = tailErr_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        headImm_d = extImm;
                        headTag_d = in_tag;
                        headErr_d = extErr;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        headImm_d = extImm;
                        headTag_d = in_tag;
                        headErr_d = extErr;
                    end else if (push) begin
                        tailImm_d = extImm;
                        tailTag_d = in_tag;
                        tailErr_d = extErr;
                        state_d   = OCC_TWO;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        headImm_d = tailImm_q;
                        headTag_d = tailTag_q;
                        headErr_d = tailErr_q;
                        state_d   = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // State and slot registers. Clearing the slots on reset makes the
    // outputs read as zero straight out of reset, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            headImm_q <= '0;
            headTag_q <= '0;
            headErr_q <= 1'b0;
            tailImm_q <= '0;
            tailTag_q <= '0;
            tailErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            headImm_q <= headImm_d;
            headTag_q <= headTag_d;
            headErr_q <= headErr_d;
            tailImm_q <= tailImm_d;
            tailTag_q <= tailTag_d;
            tailErr_q <= tailErr_d;
        end
    end

endmodule : imm_ext_pipe
